// File: rtl/game_round_timer.sv
// Round countdown timer on an Avalon-MM slave: counts externally supplied ticks down to
// whole seconds, flags expiry with an optional interrupt, and warns as the round nears its end.
module game_round_timer #(
   parameter int DEF_DURATION = 60,
   parameter int DEF_TPS      = 1000,
   parameter int DEF_WARN     = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   input  logic        tick,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        round_active,
   output logic        warn
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t      state, state_next;
   logic [15:0] remaining, remaining_next;
   logic [15:0] prescale, prescale_next;
   logic        expired, expired_next;
   logic [15:0] duration, tps, warn_thresh;
   logic        auto_restart, irq_en;
   logic        wr, status_wr, ctrl_wr;
   logic        start, stop, pause, resume;
   logic [15:0] tps_last;

   assign wr        = chipselect & ~write_n;
   assign status_wr = wr && (address == 3'd0);
   assign ctrl_wr   = wr && (address == 3'd1);
   assign start     = ctrl_wr & writedata[2];
   assign stop      = ctrl_wr & writedata[3];
   assign pause     = ctrl_wr & writedata[4];
   assign resume    = ctrl_wr & writedata[5];

   // A tps of zero behaves as one tick per second.
   assign tps_last = (tps == 16'd0) ? 16'd0 : tps - 16'd1;

   assign round_active = (state == RUN) || (state == PAUSE);
   assign irq          = expired & irq_en;
   assign warn         = round_active && (remaining != 16'd0) && (remaining <= warn_thresh);

   // Start/stop outrank pause/resume, which outrank tick counting; expiry outranks a status clear.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      prescale_next  = prescale;
      expired_next   = expired;
      if (status_wr)
         expired_next = 1'b0;
      if (start) begin
         remaining_next = duration;
         prescale_next  = 16'd0;
         if (duration == 16'd0) begin
            state_next   = DONE;
            expired_next = 1'b1;
         end else begin
            state_next = RUN;
         end
      end else if (stop) begin
         state_next    = IDLE;
         prescale_next = 16'd0;
      end else if (pause && (state == RUN)) begin
         state_next = PAUSE;
      end else if (resume && (state == PAUSE)) begin
         state_next = RUN;
      end else if ((state == RUN) && tick) begin
         if (prescale == tps_last) begin
            prescale_next = 16'd0;
            if (remaining == 16'd1) begin
               expired_next = 1'b1;
               if (auto_restart) begin
                  remaining_next = duration;
               end else begin
                  remaining_next = 16'd0;
                  state_next     = DONE;
               end
            end else if (remaining != 16'd0) begin
               remaining_next = remaining - 16'd1;
            end
         end else begin
            prescale_next = prescale + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         remaining <= 16'd0;
         prescale  <= 16'd0;
         expired   <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         prescale  <= prescale_next;
         expired   <= expired_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         auto_restart <= 1'b0;
         irq_en       <= 1'b0;
         duration     <= 16'(DEF_DURATION);
         tps          <= 16'(DEF_TPS);
         warn_thresh  <= 16'(DEF_WARN);
      end else if (wr) begin
         case (address)
            3'd1: begin
               irq_en       <= writedata[0];
               auto_restart <= writedata[1];
            end
            3'd2:    duration    <= writedata;
            3'd3:    tps         <= writedata;
            3'd5:    warn_thresh <= writedata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= 16'd0;
      end else begin
         case (address)
            3'd0:    readdata <= {13'd0, warn, (state == RUN), expired};
            3'd1:    readdata <= {14'd0, auto_restart, irq_en};
            3'd2:    readdata <= duration;
            3'd3:    readdata <= tps;
            3'd4:    readdata <= remaining;
            3'd5:    readdata <= warn_thresh;
            default: readdata <= 16'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_game_round_timer.sv
// Directed bench for game_round_timer: register reads go through an expected-value queue
// that is filled when a read is issued and drained when the registered data appears.
module tb_game_round_timer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic        tick;
   logic [15:0] readdata;
   logic        irq;
   logic        round_active;
   logic        warn;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [15:0] exp_q[$];
   string       tag_q[$];

   game_round_timer dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .tick(tick),
      .readdata(readdata),
      .irq(irq),
      .round_active(round_active),
      .warn(warn)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_pop();
      logic [15:0] e;
      string t;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, readdata, e);
      end
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic pulse_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic read_check(input logic [2:0] a, input logic [15:0] e, input string tag);
      @(negedge clk);
      address = a;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      check_pop();
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 16'd0;
      tick       = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_readdata", readdata, 16'd0);
      check("reset_irq", {15'd0, irq}, 16'd0);
      check("reset_active", {15'd0, round_active}, 16'd0);
      check("reset_warn", {15'd0, warn}, 16'd0);
      reset_n = 1'b1;
      read_check(3'd2, 16'd60, "reset_duration");
      read_check(3'd3, 16'd1000, "reset_tps");
      read_check(3'd5, 16'd10, "reset_warn_thresh");
      read_check(3'd4, 16'd0, "reset_remaining");
      read_check(3'd0, 16'd0, "reset_status");
      read_check(3'd1, 16'd0, "reset_control");

      // tps=2, duration=3: remaining steps on every second tick
      write_reg(3'd3, 16'd2);
      write_reg(3'd2, 16'd3);
      write_reg(3'd1, 16'h0004);
      check("a_active", {15'd0, round_active}, 16'd1);
      pulse_ticks(1); read_check(3'd4, 16'd3, "a_rem_t1");
      pulse_ticks(1); read_check(3'd4, 16'd2, "a_rem_t2");
      read_check(3'd0, 16'h0006, "a_status_running");
      pulse_ticks(1); read_check(3'd4, 16'd2, "a_rem_t3");
      pulse_ticks(1); read_check(3'd4, 16'd1, "a_rem_t4");
      pulse_ticks(1); read_check(3'd4, 16'd1, "a_rem_t5");
      pulse_ticks(1); read_check(3'd4, 16'd0, "a_rem_t6");
      read_check(3'd0, 16'h0001, "a_status_done");
      check("a_irq", {15'd0, irq}, 16'd0);
      check("a_inactive", {15'd0, round_active}, 16'd0);
      pulse_ticks(2); read_check(3'd4, 16'd0, "a_rem_floor");

      // Auto-restart with interrupt enabled
      write_reg(3'd0, 16'd0);
      write_reg(3'd3, 16'd1);
      write_reg(3'd2, 16'd2);
      write_reg(3'd1, 16'h0007);
      pulse_ticks(2);
      check("b_irq_set", {15'd0, irq}, 16'd1);
      read_check(3'd4, 16'd2, "b_rem_reload");
      read_check(3'd0, 16'h0007, "b_status");
      write_reg(3'd0, 16'hFFFF);
      check("b_irq_clear", {15'd0, irq}, 16'd0);
      write_reg(3'd1, 16'h0008);
      check("b_stop_inactive", {15'd0, round_active}, 16'd0);
      read_check(3'd4, 16'd2, "b_rem_kept");

      // Warning window and pause/resume
      write_reg(3'd2, 16'd5);
      write_reg(3'd5, 16'd2);
      write_reg(3'd1, 16'h0004);
      pulse_ticks(2);
      check("c_warn_low", {15'd0, warn}, 16'd0);
      pulse_ticks(1);
      check("c_warn_high", {15'd0, warn}, 16'd1);
      write_reg(3'd1, 16'h0010);
      read_check(3'd0, 16'h0004, "c_status_paused");
      check("c_paused_active", {15'd0, round_active}, 16'd1);
      pulse_ticks(4);
      read_check(3'd4, 16'd2, "c_rem_paused");
      write_reg(3'd1, 16'h0020);
      pulse_ticks(1);
      read_check(3'd4, 16'd1, "c_rem_resumed");
      pulse_ticks(1);
      check("c_warn_done", {15'd0, warn}, 16'd0);
      read_check(3'd0, 16'h0001, "c_status_done");

      // Zero duration expires immediately; start+stop resolves as start
      write_reg(3'd0, 16'd0);
      write_reg(3'd2, 16'd0);
      write_reg(3'd1, 16'h0004);
      read_check(3'd0, 16'h0001, "d_zero_done");
      check("d_zero_inactive", {15'd0, round_active}, 16'd0);
      write_reg(3'd0, 16'd0);
      write_reg(3'd2, 16'd4);
      write_reg(3'd1, 16'h000C);
      read_check(3'd0, 16'h0002, "d_start_stop_run");
      read_check(3'd4, 16'd4, "d_rem_loaded");

      // Status write on the expiring tick, then read latency
      write_reg(3'd1, 16'h0008);
      write_reg(3'd2, 16'd1);
      write_reg(3'd1, 16'h0004);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 16'd0; tick = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
      read_check(3'd0, 16'h0001, "e_expired_wins");
      read_check(3'd2, 16'd1, "e_read_dur");
      address = 3'd4;
      #1 check("e_latency_old", readdata, 16'd1);
      @(negedge clk);
      check("e_latency_new", readdata, 16'd0);
      write_reg(3'd6, 16'hABCD);
      read_check(3'd6, 16'd0, "e_unused_addr");

      // Reset in the middle of a round, with a tick in the same cycle
      write_reg(3'd0, 16'd0);
      write_reg(3'd2, 16'd5);
      write_reg(3'd5, 16'd7);
      write_reg(3'd1, 16'h0007);
      pulse_ticks(1);
      read_check(3'd4, 16'd4, "f_rem_before");
      @(negedge clk);
      reset_n = 1'b0; tick = 1'b1;
      @(negedge clk);
      reset_n = 1'b1; tick = 1'b0;
      check("f_readdata", readdata, 16'd0);
      check("f_active", {15'd0, round_active}, 16'd0);
      check("f_warn", {15'd0, warn}, 16'd0);
      check("f_irq", {15'd0, irq}, 16'd0);
      read_check(3'd4, 16'd0, "f_remaining");
      read_check(3'd2, 16'd60, "f_duration");
      read_check(3'd3, 16'd1000, "f_tps");
      read_check(3'd5, 16'd10, "f_warn_thresh");
      read_check(3'd1, 16'd0, "f_control");
      read_check(3'd0, 16'd0, "f_status");
      pulse_ticks(2);
      read_check(3'd4, 16'd0, "f_idle_tick");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/game_round_timer.md
GAME_ROUND_TIMER -- requirements
Module: game_round_timer

Interface
REQ-001 SHALL provide parameter DEF_DURATION, default 60, reset value of round duration in seconds.
REQ-002 SHALL provide parameter DEF_TPS, default 1000, reset value of ticks per second.
REQ-003 SHALL provide parameter DEF_WARN, default 10, reset value of warning threshold in seconds.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write.
REQ-009 SHALL have port writedata  input  16  write data.
REQ-010 SHALL have port tick  input  1  one-cycle pulse from the upstream interval timer's timeout event, nominally 1 ms.
REQ-011 SHALL have port readdata  output  16  registered read data.
REQ-012 SHALL have port irq  output  1  level interrupt = expired AND irq_en.
REQ-013 SHALL have port round_active  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port warn  output  1  high when round_active and 0 < remaining <= warn_thresh.

Function
REQ-015 SHALL define the register map: 0 status {warn,running,expired} in bits [2:0], write of any value clears expired; 1 control, bits [1:0] {auto_restart,irq_en} stored, bit2 start, bit3 stop, bit4 pause, bit5 resume, bits 2-5 strobes only; 2 duration; 3 tps; 4 remaining, read-only; 5 warn_thresh; 6-7 read 0, writes ignored.
REQ-016 SHALL treat a write as chipselect=1 and write_n=0 in one cycle, taking effect on that edge.
REQ-017 SHALL register readdata from address every clock, giving one-cycle read latency, with unused bits reading 0.
REQ-018 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-019 SHALL make start, from any state, load remaining=duration, clear prescale count, and enter RUN; if duration=0, SHALL instead enter DONE with expired set on the same edge.
REQ-020 SHALL make stop, from any state, enter IDLE with remaining kept and prescale cleared; start and stop together SHALL resolve as start.
REQ-021 SHALL make pause move RUN to PAUSE and resume move PAUSE to RUN; pause/resume in other states SHALL be ignored; start or stop in the same write SHALL take precedence over pause/resume.
REQ-022 SHALL, in RUN on tick, compare 16-bit prescale with tps-1 (tps=0 treated as 1): if equal, clear prescale and decrement remaining; otherwise increment prescale.
REQ-023 SHALL ignore tick outside RUN; prescale SHALL hold in PAUSE.
REQ-024 SHALL, when remaining decrements from 1 to 0, set expired and enter DONE, or if auto_restart=1, reload remaining=duration and stay in RUN.
REQ-025 SHALL give expiry priority over a status write in the same cycle, so expired ends set.
REQ-026 SHALL never decrement remaining below 0.
REQ-027 SHALL leave the current round unaffected by writes to duration, tps, or warn_thresh during RUN/PAUSE, except that tps and warn_thresh apply from the next tick/cycle.
REQ-028 SHALL make running (status bit1) equal to state==RUN.
REQ-029 SHALL drive irq, round_active, and warn combinationally from registered state only.

Reset
REQ-030 SHALL, with reset_n low at a clk edge, set state=IDLE, remaining=0, prescale=0, expired=0, control bits=0, duration=DEF_DURATION, tps=DEF_TPS, warn_thresh=DEF_WARN, and readdata=0.
REQ-031 SHALL hold outputs at irq=0, round_active=0, warn=0 during and after reset until a start.
REQ-032 SHALL, on reset mid-round, abort the round and discard any tick in that cycle.

Verification
REQ-033 SHALL be verified with: tps=2, duration=3, start, 6 ticks -> remaining 3,2,1,0 on ticks 2,4,6; DONE; expired=1; irq=0 (irq_en=0).
REQ-034 SHALL be verified with: irq_en=1, auto_restart=1, tps=1, duration=2, 2 ticks -> irq=1, remaining=2, running=1; status write -> irq=0.
REQ-035 SHALL be verified with: duration=5, warn_thresh=2, tps=1, 3 ticks -> warn rises when remaining=2; pause, 4 ticks -> remaining stays 2; resume, 2 ticks -> DONE, warn=0.
REQ-036 SHALL be verified with: start with duration=0 -> next cycle DONE, expired=1; control write with bits 2 and 3 both set -> RUN.
REQ-037 SHALL be verified with: status write coincident with final tick -> expired=1; read address 4 -> readdata valid one cycle later.
REQ-038 SHALL be verified with: reset_n low for one edge mid-RUN -> all REQ-030 values; tick in that cycle has no effect.
